uart_tx_fifo_sched: RTL and testbench
=====================================

// Module: uart_tx_fifo_sched
// PURPOSE
//  Drains the UART transmit byte FIFO into the UART transmitter, one byte per frame.
//  Issues the FIFO's active-low read strobe, captures the registered FIFO output and launches the transmitter.
//  Enforces a programmable idle gap between bytes and a forced pause after a maximum burst length.
//  Sits between the TX FIFO (read side) and the bit-level UART TX engine.
// PARAMETERS
//  BURST_MAX     256   bytes sent back-to-back before a forced pause (1..65535)
//  PAUSE_CYCLES  1024  clk cycles of forced pause after BURST_MAX bytes
//  TIMEOUT_CYCLES 4096 watchdog limit waiting for tx_busy_i rise (UART_TX_SCHED_TIMEOUT_EN only)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous active-low reset
//  enable_i      in   1   1 = drain FIFO; 0 = stop after current byte
//  gap_i         in   16  inter-byte idle clocks; sampled in IDLE->READ; values <2 treated as 2
//  fifo_data_i   in   8   FIFO registered read data (valid 1 clk after read strobe)
//  fifo_empty_i  in   1   FIFO empty flag, active high
//  fifo_n_re_o   out  1   FIFO read strobe, active low, exactly one clk per byte
//  tx_data_o     out  8   byte to transmitter, held stable from LOAD until WAIT_TX exits
//  tx_start_o    out  1   one-clk start pulse to transmitter
//  tx_busy_i     in   1   transmitter busy
//  busy_o        out  1   1 whenever state != IDLE
//  bytes_sent_o  out  16  count of launched bytes, wraps 65535->0
//  err_o         out  1   sticky watchdog error (0 when macro absent)
// BEHAVIOUR
//  Reset (any time, incl. mid-frame): state IDLE, fifo_n_re_o=1, tx_start_o=0, tx_data_o=0,
//   busy_o=0, bytes_sent_o=0, err_o=0, burst/gap counters 0. The in-flight byte is dropped.
//  FSM: IDLE -> READ -> CAPTURE -> LOAD -> WAIT_BUSY -> WAIT_TX -> GAP -> (READ | PAUSE | IDLE).
//  IDLE: go READ when enable_i=1 && fifo_empty_i=0 && tx_busy_i=0; latch gap_i.
//  READ: fifo_n_re_o=0 for this single clk. CAPTURE: wait 1 clk for FIFO output register.
//  LOAD: tx_data_o<=fifo_data_i, tx_start_o=1 one clk, bytes_sent_o+1, burst count+1.
//  WAIT_BUSY: wait tx_busy_i=1. WAIT_TX: wait tx_busy_i=0.
//  GAP: down-count latched gap (min 2). The FIFO empty flag lags reads by 2 clks; fifo_empty_i is
//   evaluated only on the final GAP clk. Exit: burst count==BURST_MAX -> PAUSE (count cleared);
//   enable_i=0 or fifo_empty_i=1 -> IDLE (burst count cleared); else -> READ.
//  PAUSE: PAUSE_CYCLES clks, then IDLE.
//  Latency: IDLE exit to tx_start_o = 3 clks (READ, CAPTURE, LOAD).
//  Byte-to-byte start spacing = frame time + gap + 4 clks.
//  enable_i falling mid-byte: current byte completes normally; no further reads.
//  fifo_empty_i rising after READ issued: ignored; the byte already read is always sent.
//  Never asserts fifo_n_re_o while fifo_empty_i=1 at the decision point; never two reads in flight.
// CONFIGURATION
//  UART_TX_SCHED_TIMEOUT_EN defined: WAIT_BUSY counts clks. Reaching TIMEOUT_CYCLES sets err_o=1
//   (sticky until rst) and returns to IDLE. The byte is counted in bytes_sent_o but treated as lost.
//  Undefined: WAIT_BUSY waits indefinitely; err_o tied 0; no watchdog counter synthesised.
// STRUCTURE
//  Shared package/include uart_sched_pkg: state encodings (3-bit localparams), counter widths,
//   gap minimum constant (2).
//  One sub-module: sched_down_counter (load value, enable, zero flag).
//   Reused for GAP, PAUSE and watchdog counting.
// TESTING
//  Single byte 0xA5 in FIFO, gap_i=4, tx busy 10 clks -> one n_re pulse; tx_start 3 clks after
//   IDLE exit with tx_data_o=0xA5; bytes_sent_o=1; return to IDLE.
//  FIFO of 3 bytes, gap_i=0 -> 3 reads; start-to-start spacing = busy time + 2 + 4 clks; IDLE after 3rd.
//  BURST_MAX=2, 5 bytes queued -> 2 bytes sent, PAUSE_CYCLES gap, then 2 more, pause, then 1.
//  enable_i dropped during WAIT_TX of byte 1 of 4 -> byte 1 completes, no further n_re, IDLE, bytes_sent_o=1.
//  rst asserted in WAIT_TX -> all outputs at reset values same clk; no start after release until FIFO non-empty.
//  Macro on, tx_busy_i held 0, TIMEOUT_CYCLES=16 -> err_o=1 after 16 clks in WAIT_BUSY; IDLE; err_o stays 1.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART TX FIFO scheduler: state encoding,
// counter width and the minimum inter-byte gap.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN (see uart_tx_fifo_sched).
package uart_sched_pkg;

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned GAP_MIN = 2;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READ      = 3'd1,
      S_CAPTURE   = 3'd2,
      S_LOAD      = 3'd3,
      S_WAIT_BUSY = 3'd4,
      S_WAIT_TX   = 3'd5,
      S_GAP       = 3'd6,
      S_PAUSE     = 3'd7
   } sched_state_t;

   // Gap requests below the minimum are raised to the minimum so the
   // lagging FIFO empty flag has settled before it is evaluated.
   function automatic logic [CNT_W-1:0] clamp_gap(input logic [CNT_W-1:0] g);
      return (g < CNT_W'(GAP_MIN)) ? CNT_W'(GAP_MIN) : g;
   endfunction

endpackage

// File: rtl/sched_down_counter.sv
// Loadable down counter with zero flag; shared by the GAP, PAUSE and
// watchdog phases of the scheduler (only one is active at a time).
module sched_down_counter
   import uart_sched_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   // Load has priority over decrement; count saturates at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/uart_tx_fifo_sched.sv
// Drains the UART TX byte FIFO into the bit-level transmitter, one byte per
// frame, with a programmable inter-byte gap and a forced pause after a burst.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN enables the WAIT_BUSY
// watchdog and the sticky err_o flag; without it err_o is tied low.
module uart_tx_fifo_sched
   import uart_sched_pkg::*;
#(
   parameter int unsigned BURST_MAX      = 256,
   parameter int unsigned PAUSE_CYCLES   = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] gap_i,
   input  logic [7:0]       fifo_data_i,
   input  logic             fifo_empty_i,
   output logic             fifo_n_re_o,
   output logic [7:0]       tx_data_o,
   output logic             tx_start_o,
   input  logic             tx_busy_i,
   output logic             busy_o,
   output logic [CNT_W-1:0] bytes_sent_o,
   output logic             err_o
);

   sched_state_t     r_state;
   sched_state_t     w_next;
   logic [7:0]       r_tx_data;
   logic [CNT_W-1:0] r_bytes;
   logic [CNT_W-1:0] r_burst;
   logic [CNT_W-1:0] r_gap;

   logic             w_ctr_load;
   logic [CNT_W-1:0] w_ctr_val;
   logic             w_ctr_en;
   logic             w_ctr_zero;
   logic             w_gap_latch;
   logic             w_capture;
   logic             w_launch;
   logic             w_burst_clr;
`ifdef UART_TX_SCHED_TIMEOUT_EN
   logic             w_err_set;
   logic             r_err;
`endif

   sched_down_counter #(
      .W (CNT_W)
   ) u_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_ctr_load),
      .i_load_val (w_ctr_val),
      .i_en       (w_ctr_en),
      .o_zero     (w_ctr_zero)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and per-state control strobes.
   always_comb begin
      w_next      = r_state;
      w_ctr_load  = 1'b0;
      w_ctr_val   = '0;
      w_ctr_en    = 1'b0;
      w_gap_latch = 1'b0;
      w_capture   = 1'b0;
      w_launch    = 1'b0;
      w_burst_clr = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      w_err_set   = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (enable_i && !fifo_empty_i && !tx_busy_i) begin
               w_next      = S_READ;
               w_gap_latch = 1'b1;
            end
         end
         S_READ: begin
            w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            // FIFO output register is valid now; capture so data and start
            // are presented together in LOAD.
            w_capture = 1'b1;
            w_next    = S_LOAD;
         end
         S_LOAD: begin
            w_launch   = 1'b1;
            w_ctr_load = 1'b1;
            w_ctr_val  = CNT_W'(TIMEOUT_CYCLES - 1);
            w_next     = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy_i) begin
               w_next = S_WAIT_TX;
`ifdef UART_TX_SCHED_TIMEOUT_EN
            end else if (w_ctr_zero) begin
               w_err_set   = 1'b1;
               w_burst_clr = 1'b1;
               w_next      = S_IDLE;
            end else begin
               w_ctr_en = 1'b1;
`endif
            end
         end
         S_WAIT_TX: begin
            if (!tx_busy_i) begin
               w_ctr_load = 1'b1;
               w_ctr_val  = r_gap - 1'b1;
               w_next     = S_GAP;
            end
         end
         S_GAP: begin
            if (!w_ctr_zero) begin
               w_ctr_en = 1'b1;
            end else if (r_burst == CNT_W'(BURST_MAX)) begin
               w_burst_clr = 1'b1;
               w_ctr_load  = 1'b1;
               w_ctr_val   = CNT_W'(PAUSE_CYCLES - 1);
               w_next      = S_PAUSE;
            end else if (!enable_i || fifo_empty_i) begin
               w_burst_clr = 1'b1;
               w_next      = S_IDLE;
            end else begin
               w_next = S_READ;
            end
         end
         S_PAUSE: begin
            if (w_ctr_zero) begin
               w_next = S_IDLE;
            end else begin
               w_ctr_en = 1'b1;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath registers: transmit byte, byte/burst counters, latched gap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tx_data <= '0;
         r_bytes   <= '0;
         r_burst   <= '0;
         r_gap     <= '0;
      end else begin
         if (w_capture) begin
            r_tx_data <= fifo_data_i;
         end
         if (w_launch) begin
            r_bytes <= r_bytes + 1'b1;
         end
         if (w_burst_clr) begin
            r_burst <= '0;
         end else if (w_launch) begin
            r_burst <= r_burst + 1'b1;
         end
         if (w_gap_latch) begin
            r_gap <= clamp_gap(gap_i);
         end
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   // Sticky watchdog error, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end
   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

   assign fifo_n_re_o  = (r_state != S_READ);
   assign tx_start_o   = (r_state == S_LOAD);
   assign busy_o       = (r_state != S_IDLE);
   assign tx_data_o    = r_tx_data;
   assign bytes_sent_o = r_bytes;

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Directed self-checking bench for uart_tx_fifo_sched with a FIFO model
// (empty flag lagging by 2 clks) and a transmitter model (busy for B clks).
module tb_uart_tx_fifo_sched;

   localparam int unsigned BURST   = 4;
   localparam int unsigned PAUSE   = 20;
   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable_i = 1'b0;
   logic [15:0] gap_i = '0;
   logic [7:0]  fifo_data_i = '0;
   logic        fifo_empty_i = 1'b1;
   logic        fifo_n_re_o;
   logic [7:0]  tx_data_o;
   logic        tx_start_o;
   logic        tx_busy_i;
   logic        busy_o;
   logic [15:0] bytes_sent_o;
   logic        err_o;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   logic [7:0] q[$];
   logic       e1 = 1'b1;
   int         tx_b = 10;
   int         tx_cnt = 0;
   logic       tx_hold = 1'b0;

   int         st_cyc[$];
   logic [7:0] st_dat[$];
   int         st_lat[$];
   int         nre_cnt = 0;
   int         last_idle = 0;
   int         last_busy = 0;

   uart_tx_fifo_sched #(
      .BURST_MAX      (BURST),
      .PAUSE_CYCLES   (PAUSE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable_i     (enable_i),
      .gap_i        (gap_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_n_re_o  (fifo_n_re_o),
      .tx_data_o    (tx_data_o),
      .tx_start_o   (tx_start_o),
      .tx_busy_i    (tx_busy_i),
      .busy_o       (busy_o),
      .bytes_sent_o (bytes_sent_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: registered read data, empty flag lags by two clocks.
   always @(posedge clk) begin
      if (!fifo_n_re_o) begin
         chk("rd_avail", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) fifo_data_i <= q.pop_front();
      end
      e1 <= (q.size() == 0);
      fifo_empty_i <= e1;
   end

   // Transmitter model: busy for tx_b clocks starting the clock after start.
   always @(posedge clk) begin
      if (tx_start_o && !tx_hold) tx_cnt <= tx_b;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
   end
   assign tx_busy_i = (tx_cnt != 0);

   // Monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (tx_start_o) begin
         st_cyc.push_back(cyc);
         st_dat.push_back(tx_data_o);
         st_lat.push_back(cyc - last_idle);
      end
      if (!fifo_n_re_o) nre_cnt++;
      if (!busy_o) last_idle = cyc;
      else last_busy = cyc;
   end

   task automatic clear_mon();
      st_cyc.delete();
      st_dat.delete();
      st_lat.delete();
      nre_cnt = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      enable_i = 1'b0;
      tx_hold = 1'b0;
      q.delete();
      repeat (4) @(posedge clk);
      #1;
      clear_mon();
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_starts(input int n, input int bound);
      int k;
      k = 0;
      while (st_cyc.size() < n && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      int k;
      k = 0;
      while ((busy_o || tx_busy_i) && k < bound) begin
         @(posedge clk); #1;
         k++;
      end
      chk(tag, 32'(busy_o), 32'd0);
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
   endtask

   initial begin
      logic [7:0] exp_b[9];
      exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

      // Reset values
      #12;
      chk("rst_nre",   32'(fifo_n_re_o), 32'd1);
      chk("rst_start", 32'(tx_start_o), 32'd0);
      chk("rst_data",  32'(tx_data_o), 32'd0);
      chk("rst_busy",  32'(busy_o), 32'd0);
      chk("rst_bytes", 32'(bytes_sent_o), 32'd0);
      chk("rst_err",   32'(err_o), 32'd0);
      do_reset();

      // Single byte 0xA5, gap 4, busy 10
      tx_b = 10; gap_i = 16'd4;
      push(8'hA5);
      enable_i = 1'b1;
      wait_starts(1, 200);
      wait_idle("t1_idle", 200);
      repeat (10) @(posedge clk);
      #1;
      chk("t1_starts", 32'(st_cyc.size()), 32'd1);
      chk("t1_nre",    32'(nre_cnt), 32'd1);
      chk("t1_data",   32'(st_dat[0]), 32'hA5);
      chk("t1_lat",    32'(st_lat[0]), 32'd3);
      chk("t1_bytes",  32'(bytes_sent_o), 32'd1);

      // Three bytes, gap 0 (treated as 2), busy 10: spacing 10+2+4
      do_reset();
      tx_b = 10; gap_i = 16'd0;
      push(8'h11); push(8'h22); push(8'h33);
      enable_i = 1'b1;
      wait_starts(3, 300);
      wait_idle("t2_idle", 200);
      repeat (30) @(posedge clk);
      #1;
      chk("t2_starts", 32'(st_cyc.size()), 32'd3);
      chk("t2_nre",    32'(nre_cnt), 32'd3);
      chk("t2_d0",     32'(st_dat[0]), 32'h11);
      chk("t2_d1",     32'(st_dat[1]), 32'h22);
      chk("t2_d2",     32'(st_dat[2]), 32'h33);
      chk("t2_sp1",    32'(st_cyc[1] - st_cyc[0]), 32'd16);
      chk("t2_sp2",    32'(st_cyc[2] - st_cyc[1]), 32'd16);
      chk("t2_bytes",  32'(bytes_sent_o), 32'd3);

      // Burst of 4 then pause: 9 bytes, busy 5, gap 2
      // in-burst spacing 5+2+4=11; across pause 11+PAUSE+1 (IDLE clk)=32
      do_reset();
      tx_b = 5; gap_i = 16'd2;
      for (int i = 0; i < 9; i++) push(exp_b[i]);
      enable_i = 1'b1;
      wait_starts(9, 1000);
      wait_idle("t3_idle", 200);
      chk("t3_starts", 32'(st_cyc.size()), 32'd9);
      for (int i = 1; i < 9; i++) begin
         chk($sformatf("t3_sp%0d", i), 32'(st_cyc[i] - st_cyc[i-1]),
             (i % 4 == 0) ? 32'd32 : 32'd11);
      end
      chk("t3_d8",    32'(st_dat[8]), 32'h09);
      chk("t3_bytes", 32'(bytes_sent_o), 32'd9);
`ifndef UART_TX_SCHED_TIMEOUT_EN
      chk("err_tied", 32'(err_o), 32'd0);
`endif

      // enable_i dropped during WAIT_TX of byte 1 of 4
      do_reset();
      tx_b = 10; gap_i = 16'd2;
      push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
      enable_i = 1'b1;
      wait_starts(1, 200);
      repeat (4) @(posedge clk);
      #1;
      enable_i = 1'b0;
      wait_idle("t4_idle", 200);
      repeat (40) @(posedge clk);
      #1;
      chk("t4_starts", 32'(st_cyc.size()), 32'd1);
      chk("t4_nre",    32'(nre_cnt), 32'd1);
      chk("t4_bytes",  32'(bytes_sent_o), 32'd1);
      chk("t4_fifo",   32'(q.size()), 32'd3);
      chk("t4_busy",   32'(busy_o), 32'd0);

      // rst asserted during WAIT_TX
      do_reset();
      tx_b = 10; gap_i = 16'd2;
      push(8'hD1); push(8'hD2);
      enable_i = 1'b1;
      wait_starts(1, 200);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_nre",   32'(fifo_n_re_o), 32'd1);
      chk("t5_start", 32'(tx_start_o), 32'd0);
      chk("t5_data",  32'(tx_data_o), 32'd0);
      chk("t5_busy",  32'(busy_o), 32'd0);
      chk("t5_bytes", 32'(bytes_sent_o), 32'd0);
      chk("t5_err",   32'(err_o), 32'd0);
      q.delete();
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("t5_nostart", 32'(st_cyc.size()), 32'd1);
      push(8'h5A);
      wait_starts(2, 200);
      wait_idle("t5_idle", 200);
      chk("t5_d1",     32'(st_dat[1]), 32'h5A);
      chk("t5_bytes2", 32'(bytes_sent_o), 32'd1);

`ifdef UART_TX_SCHED_TIMEOUT_EN
      // Watchdog: transmitter never goes busy
      do_reset();
      tx_hold = 1'b1; gap_i = 16'd2;
      push(8'h3C);
      enable_i = 1'b1;
      wait_starts(1, 200);
      wait_idle("t6_idle", 200);
      chk("t6_wait",  32'(last_busy - st_cyc[0]), 32'(TIMEOUT));
      chk("t6_err",   32'(err_o), 32'd1);
      chk("t6_bytes", 32'(bytes_sent_o), 32'd1);
      repeat (10) @(posedge clk);
      #1;
      chk("t6_sticky", 32'(err_o), 32'd1);
      chk("t6_busy2",  32'(busy_o), 32'd0);
      tx_hold = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
